// File: rtl/fifobram_buffer_if.sv
// fifobram_buffer_if: bundles the control, data and status signals of
// fifobram_buffer. The master drives strobes/addresses/data, the slave
// (the buffer) returns read data and status flags.
//   clear, we, waddr, wdata, wfifobram, re, raddr, rfifobram,
//   mark, rewind, unmark                  : master -> slave
//   rdata, rvalid, count, empty, full,
//   almostfull, overflow, underflow       : slave -> master
interface fifobram_buffer_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned LOG2_DEPTH = 9
);
  logic                  clear;
  logic                  we;
  logic [LOG2_DEPTH-1:0] waddr;
  logic [WIDTH-1:0]      wdata;
  logic [1:0]            wfifobram;
  logic                  re;
  logic [LOG2_DEPTH-1:0] raddr;
  logic [1:0]            rfifobram;
  logic                  mark;
  logic                  rewind;
  logic                  unmark;
  logic [WIDTH-1:0]      rdata;
  logic                  rvalid;
  logic [LOG2_DEPTH:0]   count;
  logic                  empty;
  logic                  full;
  logic                  almostfull;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clear, we, waddr, wdata, wfifobram, re, raddr, rfifobram,
           mark, rewind, unmark,
    input  rdata, rvalid, count, empty, full, almostfull, overflow, underflow
  );

  modport slave (
    input  clear, we, waddr, wdata, wfifobram, re, raddr, rfifobram,
           mark, rewind, unmark,
    output rdata, rvalid, count, empty, full, almostfull, overflow, underflow
  );
endinterface

// File: rtl/fifobram_buffer.sv
// fifobram_buffer: one dual-port array used either as directly addressed
// BRAM or as a FIFO through internal write/read pointers. Supports 1 or 2
// cycle read latency, almost-full margin, sticky overflow/underflow and a
// mark/rewind replay of the FIFO read pointer.
//   clk    : sole clock
//   resetn : asynchronous active-low reset
//   bus    : fifobram_buffer_if slave (strobes, addresses, data, flags)
module fifobram_buffer #(
  parameter int unsigned WIDTH             = 32,
  parameter int unsigned LOG2_DEPTH        = 9,
  parameter int unsigned READ_LATENCY      = 1,
  parameter int unsigned ALMOSTFULL_MARGIN = 16
) (
  input  logic             clk,
  input  logic             resetn,
  fifobram_buffer_if.slave bus
);
  localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
  localparam int unsigned PW    = LOG2_DEPTH + 1;
  typedef logic [PW-1:0] ptr_t;
  localparam ptr_t FULL_OCC = ptr_t'(DEPTH);
  localparam ptr_t AF_TH    = ptr_t'(DEPTH - ALMOSTFULL_MARGIN);

  logic [WIDTH-1:0] r_mem [DEPTH];

  ptr_t r_wr_ptr, r_rd_ptr, r_mark_ptr;
  logic r_mark_active;
  logic [LOG2_DEPTH:0] r_count;
  logic r_empty, r_full, r_almostfull, r_overflow, r_underflow;
  logic r_rd_vld0;
  logic [WIDTH-1:0] r_rd_data0;

  ptr_t w_count, w_occ, w_wr_next, w_rd_next, w_mark_next, w_occ_next;
  logic w_mark_act_next, w_rewind_take;
  logic w_pop_req, w_pop_ok, w_bram_rd, w_rd_ok;
  logic w_push_req, w_push_ok, w_mem_we;
  logic [LOG2_DEPTH-1:0] w_rd_addr, w_mem_waddr;
  logic w_ovf_next, w_unf_next;
  logic w_out_vld;
  logic [WIDTH-1:0] w_out_data;

  always_comb begin
    w_count       = r_wr_ptr - r_rd_ptr;
    // Marked-but-popped entries still occupy space until unmarked.
    w_occ         = r_wr_ptr - (r_mark_active ? r_mark_ptr : r_rd_ptr);
    w_rewind_take = bus.rewind & r_mark_active;
    w_pop_req     = bus.re & (bus.rfifobram == 2'b10);
    w_bram_rd     = bus.re & (bus.rfifobram == 2'b01);
    w_pop_ok      = w_pop_req & (w_count != '0) & ~bus.clear & ~w_rewind_take;
    w_rd_ok       = w_pop_ok | w_bram_rd;
    w_rd_addr     = w_bram_rd ? bus.raddr : r_rd_ptr[LOG2_DEPTH-1:0];
    w_push_req    = bus.we & bus.wfifobram[1];
    w_push_ok     = w_push_req & ~bus.clear &
                    ((w_occ != FULL_OCC) | (w_pop_ok & ~r_mark_active));
    w_mem_we      = (bus.we & (bus.wfifobram == 2'b01)) | w_push_ok;
    w_mem_waddr   = (bus.wfifobram == 2'b10) ? r_wr_ptr[LOG2_DEPTH-1:0] : bus.waddr;

    w_wr_next = r_wr_ptr;
    if (w_push_ok) begin
      if (bus.wfifobram == 2'b11)
        // waddr is taken as lying ahead of wr_ptr: an address below the
        // current low bits means the pointer has wrapped.
        w_wr_next = {r_wr_ptr[LOG2_DEPTH] ^ (bus.waddr < r_wr_ptr[LOG2_DEPTH-1:0]),
                     bus.waddr} + ptr_t'(1);
      else
        w_wr_next = r_wr_ptr + ptr_t'(1);
    end

    w_rd_next = r_rd_ptr;
    if (w_rewind_take)
      w_rd_next = r_mark_ptr;
    else if (w_pop_ok)
      w_rd_next = r_rd_ptr + ptr_t'(1);

    w_mark_next     = r_mark_ptr;
    w_mark_act_next = r_mark_active;
    if (!bus.rewind) begin
      if (bus.mark) begin
        w_mark_next     = r_rd_ptr;
        w_mark_act_next = 1'b1;
      end else if (bus.unmark) begin
        w_mark_act_next = 1'b0;
      end
    end

    w_ovf_next = r_overflow | (w_push_req & ~w_push_ok);
    w_unf_next = r_underflow | (w_pop_req & (w_count == '0));

    if (bus.clear) begin
      w_wr_next       = '0;
      w_rd_next       = '0;
      w_mark_next     = '0;
      w_mark_act_next = 1'b0;
      w_ovf_next      = 1'b0;
      w_unf_next      = 1'b0;
    end

    w_occ_next = w_wr_next - (w_mark_act_next ? w_mark_next : w_rd_next);
  end

  always_ff @(posedge clk) begin
    if (w_mem_we)
      r_mem[w_mem_waddr] <= bus.wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_mark_ptr    <= '0;
      r_mark_active <= 1'b0;
      r_count       <= '0;
      r_empty       <= 1'b1;
      r_full        <= 1'b0;
      r_almostfull  <= 1'b0;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
      r_rd_vld0     <= 1'b0;
      r_rd_data0    <= '0;
    end else begin
      r_wr_ptr      <= w_wr_next;
      r_rd_ptr      <= w_rd_next;
      r_mark_ptr    <= w_mark_next;
      r_mark_active <= w_mark_act_next;
      r_count       <= w_wr_next - w_rd_next;
      r_empty       <= (w_wr_next == w_rd_next);
      r_full        <= (w_occ_next == FULL_OCC);
      r_almostfull  <= (w_occ_next >= AF_TH);
      r_overflow    <= w_ovf_next;
      r_underflow   <= w_unf_next;
      // Read-first: the memory update of this edge is not yet visible here.
      r_rd_vld0     <= w_rd_ok;
      if (w_rd_ok)
        r_rd_data0 <= r_mem[w_rd_addr];
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic             r_rd_vld1;
      logic [WIDTH-1:0] r_rd_data1;
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_rd_vld1  <= 1'b0;
          r_rd_data1 <= '0;
        end else begin
          r_rd_vld1 <= r_rd_vld0;
          if (r_rd_vld0)
            r_rd_data1 <= r_rd_data0;
        end
      end
      assign w_out_vld  = r_rd_vld1;
      assign w_out_data = r_rd_data1;
    end else begin : g_lat1
      assign w_out_vld  = r_rd_vld0;
      assign w_out_data = r_rd_data0;
    end
  endgenerate

  assign bus.rdata      = w_out_data;
  assign bus.rvalid     = w_out_vld;
  assign bus.count      = r_count;
  assign bus.empty      = r_empty;
  assign bus.full       = r_full;
  assign bus.almostfull = r_almostfull;
  assign bus.overflow   = r_overflow;
  assign bus.underflow  = r_underflow;
endmodule

// File: doc/fifobram_buffer.md
# fifobram_buffer

Parametrised unified FIFO/BRAM buffer for `fifobram_interface` users. It is the next-generation storage behind the `wfifobram`/`rfifobram` mode bits. A single dual-port array is addressed either directly (BRAM mode) or through internal write/read pointers (FIFO mode). It adds configurable read latency, an almost-full margin, full/overflow/underflow flags, and a mark/rewind replay so that a FIFO stream can be re-read across iterations without refetching from DMA.

## Interface
- `WIDTH`, default 32: data width in bits.
- `LOG2_DEPTH`, default 9: entries = 2**LOG2_DEPTH.
- `READ_LATENCY`, default 1: cycles from accepted read to `rvalid`. Legal values are 1 or 2.
- `ALMOSTFULL_MARGIN`, default 16: `almostfull` asserts when occupancy ≥ DEPTH − margin.

- `clk` in 1: sole clock.
- `resetn` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous flush of pointers, count, mark and flags.
- `we` in 1: write strobe.
- `waddr` in LOG2_DEPTH: direct write address.
- `wdata` in WIDTH: write data.
- `wfifobram` in 2: write mode. 01 = bram, 10 = fifo, 11 = both, 00 = write ignored.
- `re` in 1: read strobe.
- `raddr` in LOG2_DEPTH: direct read address.
- `rfifobram` in 2: read mode. 01 = bram, 10 = fifo pop, 00/11 = read ignored.
- `mark` in 1: snapshot the current FIFO read pointer.
- `rewind` in 1: restore the read pointer to the snapshot.
- `unmark` in 1: release the snapshot.
- `rdata` out WIDTH: read data.
- `rvalid` out 1: `rdata` valid for one cycle.
- `count` out LOG2_DEPTH+1: entries currently poppable.
- `empty` out 1: `count == 0`.
- `full` out 1: occupancy == DEPTH.
- `almostfull` out 1: occupancy ≥ DEPTH − ALMOSTFULL_MARGIN.
- `overflow` out 1: sticky, set by a dropped push.
- `underflow` out 1: sticky, set by a pop while empty.

## Operation
- **Registers:** `wr_ptr` and `rd_ptr` (LOG2_DEPTH+1 bits, MSB is the wrap bit), `mark_ptr`, and `mark_active`.
- **Derived values:** `count = wr_ptr − rd_ptr`. Occupancy is `wr_ptr − (mark_active ? mark_ptr : rd_ptr)`, so marked entries are protected from overwrite.
- **Write, bram (01):** `mem[waddr] <= wdata`. Pointers unchanged.
- **Write, fifo (10):** if the push is accepted, `mem[wr_ptr] <= wdata` and `wr_ptr++`.
- **Write, both (11):** if the push is accepted, `mem[waddr] <= wdata` and `wr_ptr <= {wrap-adjusted}waddr+1`. This counts as one push.
- **Push acceptance:** accepted when not full, or when full with an accepted pop in the same cycle and `mark_active`=0. A rejected push leaves memory untouched and sets `overflow`.
- **Read, bram (01):** always accepted. Returns `mem[raddr]`.
- **Read, fifo (10):** accepted when `count` ≠ 0. Returns `mem[rd_ptr]` and `rd_ptr++`. A pop while empty gives no `rvalid` and sets `underflow`.
- **Simultaneous push and pop:** `count` is unchanged. A pop on `count==0` with a simultaneous push is rejected, since the new entry is not yet visible.
- **Same-address write and read:** read-first; the old data is returned.
- **`mark`:** `mark_ptr <= rd_ptr` and `mark_active <= 1`. If a pop happens in the same cycle, the pre-pop pointer is captured.
- **`rewind`:** when `mark_active`, `rd_ptr <= mark_ptr` and any same-cycle pop is discarded. `mark_active` stays set. Rewind with no active mark is a no-op.
- **`unmark`:** `mark_active <= 0`. Priority is rewind > mark > unmark.
- **`clear`:** pointers, `mark_active` and sticky flags go to 0. Reads already in flight in the pipeline still complete.
- **Reset values:** `rdata`=0, `rvalid`=0, `count`=0, `empty`=1, `full`=0, `almostfull`=0, `overflow`=0, `underflow`=0. All pointers are 0. Memory contents are undefined.

## Timing
- **Writes:** visible to a bram read issued on the next cycle.
- **FIFO push to pop:** a pushed entry is poppable on the next cycle (`count` updates one cycle after `we`).
- **Read latency:** `rvalid`/`rdata` appear exactly READ_LATENCY cycles after an accepted read. Reads can be issued every cycle, so throughput is 1/cycle. The output registers reset to 0.
- **Flags:** `count`, `empty`, `full` and `almostfull` are registered and reflect all events of the previous cycle.
- **Async reset:** `resetn` low clears everything immediately, mid-operation included. Any in-flight `rvalid` is dropped.

## Test plan
- **Basic FIFO, DEPTH=16, margin 4:**
  - Push 16 words 0..15: `almostfull` rises after the 12th, `full` after the 16th.
  - A 17th push sets `overflow`, and `count` stays 16.
  - Pop 16: data 0..15 in order, each with `rvalid` exactly READ_LATENCY cycles after `re`.
  - A 17th pop sets `underflow` with no `rvalid`.
- **BRAM mode:** write 0xA5 to address 7; read address 7 on the next cycle gives 0xA5. In the same cycle, write 0x5A to address 7 and read address 7: the read returns 0xA5.
- **Wrap-around:** push/pop interleaved for 40 entries at DEPTH=16. Data order is preserved, `count` never exceeds 16, and no flag is set.
- **Mark/rewind:**
  - Push 8, mark, pop 8 (data 0..7), rewind: `count`=8, and popping again returns 0..7.
  - With the mark held, pushing 9 more at DEPTH=16 gives `full` after 8, and the 9th sets `overflow`.
- **Simultaneous push/pop at full, unmarked:** both are accepted, and `count` stays 16.
- **Reset mid-read:**
  - Assert `resetn` low one cycle after `re`: no `rvalid` appears, and all outputs are at reset values.
  - `clear` with 5 entries gives `count`=0 and `empty`=1 on the next cycle.
